// File: rtl/gray_sweep_ctrl_pkg.sv
// Shared types for the Gray-code sweep controller: FSM state encoding and
// direction constants.
package gray_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/gray_sweep_ctrl_if.sv
// Sweep request plus valid/ready Gray-code output stream.
// The master side requests sweeps and consumes codes; the slave side is the controller.
interface gray_sweep_ctrl_if #(
  parameter int W = 3
);
  logic         start;
  logic         dir;
  logic [W-1:0] start_bin;
  logic [W:0]   len;
  logic         abort;
  logic         out_ready;
  logic         gray_valid;
  logic [W-1:0] gray_out;
  logic         busy;
  logic         done;

  modport master (
    output start, dir, start_bin, len, abort, out_ready,
    input  gray_valid, gray_out, busy, done
  );

  modport slave (
    input  start, dir, start_bin, len, abort, out_ready,
    output gray_valid, gray_out, busy, done
  );
endinterface

// File: rtl/gray_sweep_ctrl_encoder.sv
// Combinational binary-to-Gray conversion: the MSB passes through and every
// lower bit is the XOR of itself with its upper neighbour.
module gray_encoder #(
  parameter int W = 3
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);
  genvar gi;

  assign gray[W-1] = bin[W-1];

  generate
    for (gi = 0; gi < W - 1; gi++) begin : g_bit
      assign gray[gi] = bin[gi] ^ bin[gi+1];
    end
  endgenerate
endmodule

// File: rtl/gray_sweep_ctrl.sv
// Bounded, back-pressurable Gray-code sweep sequencer. MOD_VALUE must be a
// power of two (>= 2) so that the wrap step is also a single-bit change.
module gray_sweep_ctrl
  import gray_sweep_pkg::*;
#(
  parameter  int MOD_VALUE = 8,
  localparam int W         = $clog2(MOD_VALUE)
) (
  input  logic                clk,
  input  logic                rstn,
  gray_sweep_ctrl_if.slave    bus
);
  localparam logic [W:0] MOD_LEN = (W+1)'(MOD_VALUE);

  state_t       state_reg, state_next;
  logic [W-1:0] bin_reg, bin_next;
  logic [W-1:0] gray_reg, gray_next;
  logic [W:0]   rem_reg, rem_next;
  logic [W:0]   len_eff;
  logic         dir_reg, dir_next;
  logic         transfer;

  // Oversized lengths are clamped so the sweep never repeats a code.
  assign len_eff  = (bus.len > MOD_LEN) ? MOD_LEN : bus.len;
  assign transfer = (state_reg == EMIT) && bus.out_ready;

  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    rem_next   = rem_reg;
    dir_next   = dir_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          bin_next   = bus.start_bin;
          dir_next   = bus.dir;
          rem_next   = len_eff;
          state_next = (len_eff != '0) ? EMIT : DONE;
        end
      end
      EMIT: begin
        if (transfer) begin
          if (rem_reg > (W+1)'(1)) begin
            rem_next = rem_reg - (W+1)'(1);
            bin_next = (dir_reg == DIR_DN) ? bin_reg - W'(1) : bin_reg + W'(1);
          end else begin
            rem_next   = '0;
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A transfer in the abort cycle has already advanced bin; only the sweep ends.
    if (bus.abort) begin
      state_next = IDLE;
      rem_next   = '0;
    end
  end

  // Encoding the next binary value keeps gray_out a plain register output.
  gray_encoder #(.W(W)) u_enc (
    .bin  (bin_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      gray_reg  <= '0;
      rem_reg   <= '0;
      dir_reg   <= DIR_UP;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      gray_reg  <= gray_next;
      rem_reg   <= rem_next;
      dir_reg   <= dir_next;
    end
  end

  assign bus.gray_valid = (state_reg == EMIT);
  assign bus.gray_out   = gray_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.done       = (state_reg == DONE);

  len_in_range: assert property (
    @(posedge clk) disable iff (!rstn)
    (state_reg == IDLE && bus.start && !bus.abort) |-> (bus.len <= MOD_LEN)
  );
endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Directed self-checking bench for gray_sweep_ctrl with MOD_VALUE = 8.
module tb_gray_sweep_ctrl;
  localparam int W = 3;

  logic clk;
  logic rstn;
  int   checks;
  int   failures;

  gray_sweep_ctrl_if #(.W(W)) bus ();

  gray_sweep_ctrl #(.MOD_VALUE(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [W-1:0] sb, input logic d, input logic [W:0] l);
    bus.start     = 1'b1;
    bus.start_bin = sb;
    bus.dir       = d;
    bus.len       = l;
    tick();
    bus.start     = 1'b0;
  endtask

  logic [W-1:0] exp_up   [4] = '{3'b101, 3'b100, 3'b000, 3'b001};
  logic [W-1:0] exp_dn   [3] = '{3'b001, 3'b000, 3'b100};
  logic         bp_rdy   [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [W-1:0] bp_gray  [6] = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b011, 3'b011};
  logic [W-1:0] exp_full [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic [W-1:0] exp_ign  [3] = '{3'b011, 3'b010, 3'b110};
  logic [W-1:0] exp_ab   [3] = '{3'b010, 3'b110, 3'b111};
  logic [W-1:0] prev_gray;

  initial begin
    checks        = 0;
    failures      = 0;
    rstn          = 1'b0;
    bus.start     = 1'b0;
    bus.dir       = 1'b0;
    bus.start_bin = '0;
    bus.len       = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("reset_valid", 32'(bus.gray_valid), 32'd0);
    chk("reset_gray",  32'(bus.gray_out),   32'd0);
    chk("reset_busy",  32'(bus.busy),       32'd0);
    chk("reset_done",  32'(bus.done),       32'd0);
    rstn = 1'b1;
    tick();

    // Up sweep crossing the 7 -> 0 wrap.
    request(3'd6, 1'b0, 4'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("up_valid%0d", i), 32'(bus.gray_valid), 32'd1);
      chk($sformatf("up_gray%0d", i),  32'(bus.gray_out),   32'(exp_up[i]));
      chk($sformatf("up_done%0d", i),  32'(bus.done),       32'd0);
      $display("up   xfer %0d gray=%b", i, bus.gray_out);
      tick();
    end
    chk("up_done_pulse", 32'(bus.done),       32'd1);
    chk("up_done_busy",  32'(bus.busy),       32'd1);
    chk("up_done_valid", 32'(bus.gray_valid), 32'd0);
    tick();
    chk("up_after_done", 32'(bus.done), 32'd0);
    chk("up_after_busy", 32'(bus.busy), 32'd0);

    // Down sweep crossing the 0 -> 7 wrap.
    request(3'd1, 1'b1, 4'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("dn_valid%0d", i), 32'(bus.gray_valid), 32'd1);
      chk($sformatf("dn_gray%0d", i),  32'(bus.gray_out),   32'(exp_dn[i]));
      $display("down xfer %0d gray=%b", i, bus.gray_out);
      tick();
    end
    chk("dn_done_pulse", 32'(bus.done), 32'd1);
    tick();
    chk("dn_after_done", 32'(bus.done), 32'd0);

    // Backpressure: codes must hold while out_ready is low.
    request(3'd0, 1'b0, 4'd3);
    for (int i = 0; i < 6; i++) begin
      bus.out_ready = bp_rdy[i];
      chk($sformatf("bp_valid%0d", i), 32'(bus.gray_valid), 32'd1);
      chk($sformatf("bp_gray%0d", i),  32'(bus.gray_out),   32'(bp_gray[i]));
      $display("bp   cycle %0d ready=%0d gray=%b", i, bp_rdy[i], bus.gray_out);
      tick();
    end
    bus.out_ready = 1'b1;
    chk("bp_done_pulse", 32'(bus.done), 32'd1);
    tick();
    chk("bp_after_busy", 32'(bus.busy), 32'd0);

    // Full cycle with Hamming-distance scoreboard.
    request(3'd0, 1'b0, 4'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("full_valid%0d", i), 32'(bus.gray_valid), 32'd1);
      chk($sformatf("full_gray%0d", i),  32'(bus.gray_out),   32'(exp_full[i]));
      if (i > 0)
        chk($sformatf("full_ham%0d", i), 32'($countones(prev_gray ^ bus.gray_out)), 32'd1);
      prev_gray = bus.gray_out;
      $display("full xfer %0d gray=%b", i, bus.gray_out);
      tick();
    end
    chk("full_wrap_ham", 32'($countones(prev_gray ^ exp_full[0])), 32'd1);
    chk("full_done_pulse", 32'(bus.done), 32'd1);
    tick();

    // Clean restart with a single code.
    request(3'd0, 1'b0, 4'd1);
    chk("one_valid", 32'(bus.gray_valid), 32'd1);
    chk("one_gray",  32'(bus.gray_out),   32'd0);
    tick();
    chk("one_done_pulse", 32'(bus.done),       32'd1);
    chk("one_done_valid", 32'(bus.gray_valid), 32'd0);
    tick();

    // Zero length: straight to DONE without emitting.
    request(3'd5, 1'b0, 4'd0);
    chk("zero_valid", 32'(bus.gray_valid), 32'd0);
    chk("zero_done",  32'(bus.done),       32'd1);
    chk("zero_busy",  32'(bus.busy),       32'd1);
    tick();
    chk("zero_after_done", 32'(bus.done), 32'd0);
    chk("zero_after_busy", 32'(bus.busy), 32'd0);

    // start while busy (mid-sweep and in DONE) is ignored.
    request(3'd2, 1'b0, 4'd3);
    for (int i = 0; i < 3; i++) begin
      bus.start     = (i == 1);
      bus.start_bin = 3'd5;
      bus.dir       = 1'b1;
      bus.len       = 4'd2;
      chk($sformatf("ign_gray%0d", i), 32'(bus.gray_out), 32'(exp_ign[i]));
      $display("ign  xfer %0d gray=%b", i, bus.gray_out);
      tick();
    end
    bus.start = 1'b1;
    chk("ign_done_pulse", 32'(bus.done), 32'd1);
    tick();
    bus.start = 1'b0;
    chk("ign_done_busy",  32'(bus.busy),       32'd0);
    chk("ign_done_valid", 32'(bus.gray_valid), 32'd0);
    tick();

    // Abort coincident with the third transfer of five.
    request(3'd3, 1'b0, 4'd5);
    for (int i = 0; i < 3; i++) begin
      bus.abort = (i == 2);
      chk($sformatf("ab_gray%0d", i), 32'(bus.gray_out), 32'(exp_ab[i]));
      $display("ab   xfer %0d gray=%b", i, bus.gray_out);
      tick();
    end
    bus.abort = 1'b0;
    chk("ab_valid", 32'(bus.gray_valid), 32'd0);
    chk("ab_busy",  32'(bus.busy),       32'd0);
    chk("ab_done",  32'(bus.done),       32'd0);
    tick();
    chk("ab_no_late_done", 32'(bus.done), 32'd0);

    // Abort beats start in IDLE: nothing is latched.
    bus.abort = 1'b1;
    request(3'd1, 1'b0, 4'd2);
    bus.abort = 1'b0;
    chk("abst_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-EMIT clears outputs without a clock edge.
    request(3'd5, 1'b0, 4'd4);
    tick();
    chk("rst_pre_gray", 32'(bus.gray_out), 32'b101);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.gray_valid), 32'd0);
    chk("arst_gray",  32'(bus.gray_out),   32'd0);
    chk("arst_busy",  32'(bus.busy),       32'd0);
    tick();
    rstn = 1'b1;
    tick();
    chk("arst_no_done", 32'(bus.done), 32'd0);
    chk("arst_idle",    32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
